// File: rtl/lsu_align.sv
// lsu_align: single-outstanding RV32I load/store unit in front of a
// word-wide data memory with a one-cycle registered read port.
// Sub-word stores are done as read-modify-write.
// Loads return the selected lane with sign or zero extension.
//
//   state  | meaning
//   IDLE   | ready for a request; request fields latched on accept
//   RD     | memory read strobe for the latched word address
//   CAPT   | read data valid: extract load lane or merge store data
//   WR     | memory write strobe with the full merged/stored word
//   RESP   | one-cycle response pulse, then back to IDLE
module lsu_align #(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_ren,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAPT,
    S_WR,
    S_RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  // Holds raw store data from accept, then the merged word after CAPT.
  logic [31:0]       wbuf_q;

  logic              accept;
  logic              f3_legal;
  logic              misalign;
  logic              out_of_range;
  logic              req_err;
  logic [ADDR_W-1:0] req_word_addr;

  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign accept        = i_req_valid && (state_q == S_IDLE);
  assign req_word_addr = {i_req_addr[ADDR_W-1:2], 2'b00};

  // Request legality: funct3 per direction, natural alignment, range.
  always_comb begin
    f3_legal = 1'b0;
    case (i_req_funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !i_req_we;
      default:          f3_legal = 1'b0;
    endcase
    misalign     = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                   ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    out_of_range = (req_word_addr >= MEM_LIMIT);
    req_err      = !f3_legal || misalign || out_of_range;
  end

  // Load lane selection and extension from the word returned in CAPT.
  always_comb begin
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: lane_byte = i_mem_rdata[7:0];
      2'd1: lane_byte = i_mem_rdata[15:8];
      2'd2: lane_byte = i_mem_rdata[23:16];
      2'd3: lane_byte = i_mem_rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      F3_B:    load_ext = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_ext = {24'h000000, lane_byte};
      F3_H:    load_ext = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_ext = {16'h0000, lane_half};
      default: load_ext = i_mem_rdata;
    endcase
  end

  // Sub-word store merge: new byte/half into its lane, rest from memory.
  always_comb begin
    merged = i_mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wbuf_q[7:0];
        2'd1: merged[15:8]  = wbuf_q[7:0];
        2'd2: merged[23:16] = wbuf_q[7:0];
        2'd3: merged[31:24] = wbuf_q[7:0];
        default: merged = i_mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wbuf_q[15:0];
    end else begin
      merged[15:0] = wbuf_q[15:0];
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; strobes are pure functions of state.
  always_comb begin
    state_d      = state_q;
    o_req_ready  = 1'b0;
    o_mem_ren    = 1'b0;
    o_mem_wren   = 1'b0;
    o_resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (req_err) begin
            state_d = S_RESP;
          end else if (i_req_we && (i_req_funct3 == F3_W)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        o_mem_ren = 1'b1;
        state_d   = S_CAPT;
      end
      S_CAPT: begin
        state_d = we_q ? S_WR : S_RESP;
      end
      S_WR: begin
        o_mem_wren = 1'b1;
        state_d    = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch and write buffer; the buffer is rebuilt in CAPT for RMW.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      wbuf_q   <= 32'h0;
    end else if (accept) begin
      addr_q   <= i_req_addr;
      we_q     <= i_req_we;
      funct3_q <= i_req_funct3;
      wbuf_q   <= i_req_wdata;
    end else if ((state_q == S_CAPT) && we_q) begin
      wbuf_q <= merged;
    end
  end

  // Response data/error, updated only on the way into RESP and held after.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_resp_rdata <= 32'h0;
      o_resp_err   <= 1'b0;
    end else if (accept && req_err) begin
      o_resp_rdata <= 32'h0;
      o_resp_err   <= 1'b1;
    end else if ((state_q == S_CAPT) && !we_q) begin
      o_resp_rdata <= load_ext;
      o_resp_err   <= 1'b0;
    end else if (state_q == S_WR) begin
      o_resp_rdata <= 32'h0;
      o_resp_err   <= 1'b0;
    end
  end

  assign o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_wdata = wbuf_q;

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed test of lsu_align against a request-level model.
// The model predicts, per accepted request, the response latency, strobe
// cycles, memory address/data and the extended load result.
module tb_lsu_align;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [2:0]  i_req_funct3 = 3'b000;
  logic [31:0] i_req_addr = 32'h0;
  logic [31:0] i_req_wdata = 32'h0;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_mem_ren;
  logic        o_mem_wren;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = 32'h0;

  lsu_align #(.MEM_BYTES(512), .ADDR_W(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .o_mem_ren    (o_mem_ren),
    .o_mem_wren   (o_mem_wren),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Memory seen by the DUT, and the model's view of what it should hold.
  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];

  always @(posedge i_clk) begin
    if (o_mem_ren) i_mem_rdata <= mem[o_mem_addr[8:2]];
    else           i_mem_rdata <= 32'hA5A5_5A5A;
    if (o_mem_wren) mem[o_mem_addr[8:2]] <= o_mem_wdata;
  end

  typedef struct {
    int          acc;
    int          lat;
    int          ren_rel;
    int          wren_rel;
    logic        we;
    logic        err;
    logic [31:0] addr_w;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          has_lit;
    logic [31:0] lit;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_fail = 0;
  bit in_rst = 1'b1;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Request-level model: legality, latency and data from plain arithmetic.
  task automatic push_model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input bit hl, input logic [31:0] lit);
    exp_t e;
    int size;
    bit legal;
    logic [31:0] w, v, mask;
    int sh;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    e.acc     = cyc;
    e.we      = we;
    e.addr_w  = a & ~32'd3;
    e.has_lit = hl;
    e.lit     = lit;
    e.err     = !(legal && (a % size == 0) && (e.addr_w < 32'd512));
    e.wdata   = 32'h0;
    e.rdata   = 32'h0;
    e.ren_rel = -1;
    e.wren_rel = -1;
    sh = 8 * int'(a % 4);
    if (e.err) begin
      e.lat = 1;
    end else begin
      w = ref_mem[e.addr_w / 4];
      if (!we) begin
        e.lat = 3;
        e.ren_rel = 1;
        v = w >> sh;
        if (size == 1) begin
          v = v & 32'hFF;
          if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        e.rdata = v;
      end else if (size == 4) begin
        e.lat = 2;
        e.wren_rel = 1;
        e.wdata = wd;
      end else begin
        e.lat = 4;
        e.ren_rel = 1;
        e.wren_rel = 3;
        mask = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
        e.wdata = (w & ~mask) | ((wd << sh) & mask);
      end
    end
    q.push_back(e);
  endtask

  // Compare process: every cycle, away from the rising edge.
  exp_t ce;
  int   rel;
  bit   x_ready, x_valid, x_ren, x_wren;
  always begin
    @(negedge i_clk);
    #1;
    if (in_rst) begin
      chk("rst_ren", o_mem_ren, 0);
      chk("rst_wren", o_mem_wren, 0);
      chk("rst_valid", o_resp_valid, 0);
      chk("rst_rdata", o_resp_rdata, 0);
      chk("rst_err", o_resp_err, 0);
      chk("rst_addr", o_mem_addr, 0);
      chk("rst_wdata", o_mem_wdata, 0);
    end else begin
      x_ready = 1; x_valid = 0; x_ren = 0; x_wren = 0;
      if (q.size() > 0) begin
        ce  = q[0];
        rel = cyc - ce.acc;
        x_ready = (rel == 0);
        x_valid = (rel == ce.lat);
        x_ren   = (rel == ce.ren_rel);
        x_wren  = (rel == ce.wren_rel);
      end
      chk("ready", o_req_ready, x_ready);
      chk("resp_valid", o_resp_valid, x_valid);
      chk("ren", o_mem_ren, x_ren);
      chk("wren", o_mem_wren, x_wren);
      if (x_ren) chk("ren_addr", o_mem_addr, ce.addr_w);
      if (x_wren) begin
        chk("wr_addr", o_mem_addr, ce.addr_w);
        chk("wr_data", o_mem_wdata, ce.wdata);
        if (ce.has_lit) chk("wr_data_lit", o_mem_wdata, ce.lit);
        ref_mem[ce.addr_w / 4] = ce.wdata;
      end
      if (x_valid) begin
        last_rdata = ce.rdata;
        last_err   = ce.err;
        if (ce.has_lit && !(ce.we && !ce.err)) chk("rdata_lit", o_resp_rdata, ce.lit);
        void'(q.pop_front());
      end
      chk("rdata", o_resp_rdata, last_rdata);
      chk("err", o_resp_err, last_err);
    end
  end

  // Drive one request from a falling edge; returns on the falling edge after accept.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit keep, input bit hl,
                       input logic [31:0] lit);
    bit done = 0;
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = a;
    i_req_wdata  = wd;
    for (int k = 0; k < 40 && !done; k++) begin
      if (o_req_ready) begin
        push_model(we, f3, a, wd, hl, lit);
        done = 1;
      end
      @(negedge i_clk);
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout addr=%h actual=not_ready required=ready", a);
    end
    if (!keep) begin
      i_req_valid  = 1'b0;
      i_req_we     = 1'b1;
      i_req_funct3 = 3'b010;
      i_req_addr   = 32'h0000_0040;
      i_req_wdata  = 32'h5555_AAAA;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge i_clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout actual=%0d_pending required=0", q.size());
    end
  endtask

  task automatic do_reset(input int n);
    i_rst_n = 1'b0;
    in_rst  = 1'b1;
    q.delete();
    last_rdata = 32'h0;
    last_err   = 1'b0;
    repeat (n) @(negedge i_clk);
    i_rst_n = 1'b1;
    in_rst  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    mem[32'h40 >> 2] = 32'h80FF_7F01;
    mem[32'h44 >> 2] = 32'h1122_3344;
    mem[32'h4C >> 2] = 32'hCAFE_F00D;
    mem[32'h50 >> 2] = 32'hFFFF_FFFF;
    mem[127]         = 32'h0102_0304;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];

    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    in_rst  = 1'b0;
    @(negedge i_clk);

    // Load extraction over 0x80FF7F01.
    issue(0, 3'b000, 32'h42, 0, 0, 1, 32'hFFFF_FFFF);
    issue(0, 3'b100, 32'h43, 0, 0, 1, 32'h0000_0080);
    issue(0, 3'b001, 32'h40, 0, 0, 1, 32'h0000_7F01);
    issue(0, 3'b101, 32'h42, 0, 0, 1, 32'h0000_80FF);
    issue(0, 3'b010, 32'h40, 0, 0, 1, 32'h80FF_7F01);

    // Sub-word stores and word store.
    issue(1, 3'b000, 32'h45, 32'h0000_00AB, 0, 1, 32'h1122_AB44);
    issue(0, 3'b010, 32'h44, 0, 0, 1, 32'h1122_AB44);
    issue(1, 3'b010, 32'h44, 32'h1122_3344, 0, 1, 32'h1122_3344);
    issue(1, 3'b001, 32'h46, 32'h7777_BEEF, 0, 1, 32'hBEEF_3344);
    issue(0, 3'b010, 32'h44, 0, 0, 1, 32'hBEEF_3344);
    issue(1, 3'b010, 32'h48, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF);
    issue(0, 3'b010, 32'h48, 0, 0, 1, 32'hDEAD_BEEF);

    // Faults: misaligned, out of range, illegal funct3.
    issue(0, 3'b010, 32'h41, 0, 0, 1, 32'h0);
    issue(0, 3'b001, 32'h43, 0, 0, 1, 32'h0);
    issue(1, 3'b010, 32'h200, 32'h1234_5678, 0, 1, 32'h0);
    issue(0, 3'b011, 32'h40, 0, 0, 1, 32'h0);
    issue(1, 3'b100, 32'h40, 32'h1234_5678, 0, 1, 32'h0);
    issue(0, 3'b000, 32'hFFFF_FFFC, 0, 0, 1, 32'h0);

    // Last legal word.
    issue(1, 3'b000, 32'h1FF, 32'h0000_0077, 0, 1, 32'h7702_0304);
    issue(0, 3'b010, 32'h1FC, 0, 0, 1, 32'h7702_0304);
    issue(0, 3'b000, 32'h1FD, 0, 0, 1, 32'h0000_0003);

    // Back-to-back with valid held high.
    issue(0, 3'b010, 32'h40, 0, 1, 1, 32'h80FF_7F01);
    issue(0, 3'b000, 32'h40, 0, 1, 1, 32'h0000_0001);
    issue(1, 3'b000, 32'h50, 32'h0000_005A, 1, 1, 32'hFFFF_FF5A);
    issue(0, 3'b001, 32'h50, 0, 1, 1, 32'hFFFF_FF5A);
    issue(1, 3'b010, 32'h201, 32'h0, 1, 1, 32'h0);
    issue(0, 3'b010, 32'h50, 0, 0, 1, 32'hFFFF_FF5A);
    wait_idle();

    // Reset during CAPT of an SB: no write may reach memory.
    issue(1, 3'b000, 32'h4C, 32'h0000_0099, 0, 0, 32'h0);
    @(negedge i_clk);
    do_reset(3);
    repeat (4) @(negedge i_clk);
    chk("rst_word_kept", mem[32'h4C >> 2], 32'hCAFE_F00D);
    issue(0, 3'b010, 32'h4C, 0, 0, 1, 32'hCAFE_F00D);
    wait_idle();
    repeat (3) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
